// File: rtl/trap_pkg.sv
// Shared state encoding, CSR map and vector-address helper for the trap unit.
package trap_pkg;

    typedef enum logic [2:0] {IDLE, SAVE, REDIRECT, RETURN, HALT} trap_state_t;

    localparam logic [1:0] CSR_STATUS = 2'd0;
    localparam logic [1:0] CSR_IEN    = 2'd1;
    localparam logic [1:0] CSR_EPC    = 2'd2;
    localparam logic [1:0] CSR_CAUSE  = 2'd3;

    localparam int IE_BIT  = 0;
    localparam int PIE_BIT = 1;

    // Each vector-table slot is one 4-byte entry; wraps modulo 2^64.
    function automatic logic [63:0] vec_addr(input logic [63:0] base, input logic [63:0] slot);
        return base + (slot << 2);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Masked interrupt priority encoder: lowest active index wins, valid when any line is active.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [NUM_IRQ-1:0] act;
    assign act = irq & mask;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_unit.sv
// Exception/interrupt controller: saves EPC/cause, forces a vectored PC load, restores on mret.
// Define TRAP_NEST_EN for a 2-deep EPC/CAUSE/PIE stack; otherwise a trap inside a handler halts.
module trap_unit
    import trap_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter int          NUM_IRQ   = 4,
    parameter int          CAUSE_W   = 4,
    parameter logic [63:0] TRAP_BASE = 64'h0000_0000_0000_0100
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InstrDone,
    input  logic [XLEN-1:0]    PCnext,
    input  logic               ExcReq,
    input  logic [CAUSE_W-1:0] ExcCode,
    input  logic [XLEN-1:0]    PCcur,
    input  logic               MretReq,
    input  logic [NUM_IRQ-1:0] Irq,
    input  logic               CsrWe,
    input  logic [1:0]         CsrAddr,
    input  logic [XLEN-1:0]    CsrWdata,
    output logic [XLEN-1:0]    CsrRdata,
    output logic               PCLoad,
    output logic [XLEN-1:0]    TrapPC,
    output logic               TrapTaken,
    output logic               Stall,
    output logic               InTrap,
    output logic               Halted
);

`ifdef TRAP_NEST_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    trap_state_t        state;
    logic [1:0]         depth;
    logic               ie;
    logic [NUM_IRQ-1:0] ien;
    logic [XLEN-1:0]    epcStk   [DEPTH];
    logic [XLEN-1:0]    causeStk [DEPTH];
    logic               pieStk   [DEPTH];

    logic               pendIrq;
    logic [CAUSE_W-1:0] pendCode;
    logic [IDX_W-1:0]   pendIdx;
    logic [XLEN-1:0]    pendPc;

    logic               pcLoadQ, trapTakenQ, stallQ, haltedQ;
    logic [XLEN-1:0]    trapPcQ;

    logic [IDX_W-1:0]   irqIdx;
    logic               irqValid, full, mretOk, irqOk, top, sp;
    logic [XLEN-1:0]    causeNew, vecNew;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) uPrio (
        .irq  (Irq),
        .mask (ien),
        .idx  (irqIdx),
        .valid(irqValid)
    );

    // top = current handler's frame, sp = frame a new trap will fill.
    assign top    = depth[1];
    assign sp     = depth[0];
    assign full   = (depth == 2'(DEPTH));
    assign mretOk = MretReq && (depth != 2'd0);
    assign irqOk  = InstrDone && ie && irqValid && !full;

    always_comb begin
        causeNew = XLEN'(pendCode);
        vecNew   = XLEN'(vec_addr(TRAP_BASE, 64'(pendCode)));
        if (pendIrq) begin
            causeNew            = '0;
            causeNew[XLEN-1]    = 1'b1;
            causeNew[IDX_W-1:0] = pendIdx;
            vecNew = XLEN'(vec_addr(TRAP_BASE, (64'd1 << CAUSE_W) + 64'(pendIdx)));
        end
    end

    always_comb begin
        CsrRdata = '0;
        case (CsrAddr)
            CSR_STATUS: begin
                CsrRdata[IE_BIT]  = ie;
                CsrRdata[PIE_BIT] = pieStk[top];
            end
            CSR_IEN: CsrRdata[NUM_IRQ-1:0] = ien;
            CSR_EPC: CsrRdata = epcStk[top];
            default: CsrRdata = causeStk[top];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            depth      <= 2'd0;
            ie         <= 1'b0;
            ien        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                epcStk[i]   <= '0;
                causeStk[i] <= '0;
                pieStk[i]   <= 1'b0;
            end
            pendIrq    <= 1'b0;
            pendCode   <= '0;
            pendIdx    <= '0;
            pendPc     <= '0;
            pcLoadQ    <= 1'b0;
            trapTakenQ <= 1'b0;
            stallQ     <= 1'b0;
            haltedQ    <= 1'b0;
            trapPcQ    <= '0;
        end else begin
            pcLoadQ    <= 1'b0;
            trapTakenQ <= 1'b0;
            stallQ     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ExcReq) begin
                        stallQ <= 1'b1;
                        if (full) begin
                            state   <= HALT;
                            haltedQ <= 1'b1;
                        end else begin
                            state    <= SAVE;
                            pendIrq  <= 1'b0;
                            pendCode <= ExcCode;
                            pendPc   <= PCcur;
                        end
                    end else if (mretOk) begin
                        state   <= RETURN;
                        pcLoadQ <= 1'b1;
                        stallQ  <= 1'b1;
                        trapPcQ <= epcStk[top];
                    end else if (irqOk) begin
                        state   <= SAVE;
                        stallQ  <= 1'b1;
                        pendIrq <= 1'b1;
                        pendIdx <= irqIdx;
                        pendPc  <= PCnext;
                    end else if (CsrWe) begin
                        case (CsrAddr)
                            CSR_STATUS: begin
                                ie          <= CsrWdata[IE_BIT];
                                pieStk[top] <= CsrWdata[PIE_BIT];
                            end
                            CSR_IEN: ien         <= CsrWdata[NUM_IRQ-1:0];
                            CSR_EPC: epcStk[top] <= {CsrWdata[XLEN-1:2], 2'b00};
                            default: causeStk[top] <= CsrWdata;
                        endcase
                    end
                end
                SAVE: begin
                    epcStk[sp]   <= pendPc;
                    causeStk[sp] <= causeNew;
                    pieStk[sp]   <= ie;
                    ie           <= 1'b0;
                    state        <= REDIRECT;
                    stallQ       <= 1'b1;
                    pcLoadQ      <= 1'b1;
                    trapTakenQ   <= 1'b1;
                    trapPcQ      <= vecNew;
                end
                REDIRECT: begin
                    depth <= depth + 2'd1;
                    state <= IDLE;
                end
                RETURN: begin
                    ie    <= pieStk[top];
                    depth <= depth - 2'd1;
                    state <= IDLE;
                end
                HALT:    stallQ <= 1'b1;
                default: state  <= IDLE;
            endcase
        end
    end

    assign PCLoad    = pcLoadQ;
    assign TrapPC    = trapPcQ;
    assign TrapTaken = trapTakenQ;
    assign Stall     = stallQ;
    assign Halted    = haltedQ;
    assign InTrap    = (depth != 2'd0);

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit with a transaction-level model checked every cycle.
module tb_trap_unit;
    import trap_pkg::*;

    localparam int          NUM_IRQ = 4;
    localparam logic [63:0] BASE    = 64'h100;
`ifdef TRAP_NEST_EN
    localparam int MAXD = 2;
`else
    localparam int MAXD = 1;
`endif

    logic        Clk = 0, Reset = 0, InstrDone = 0, ExcReq = 0, MretReq = 0, CsrWe = 0;
    logic [63:0] PCnext = 0, PCcur = 0, CsrWdata = 0;
    logic [3:0]  ExcCode = 0, Irq = 0;
    logic [1:0]  CsrAddr = 0;
    logic [63:0] CsrRdata, TrapPC;
    logic        PCLoad, TrapTaken, Stall, InTrap, Halted;

    int tests = 0, fails = 0;

    trap_unit #(.XLEN(64), .NUM_IRQ(NUM_IRQ), .CAUSE_W(4), .TRAP_BASE(BASE)) dut (
        .Clk(Clk), .Reset(Reset), .InstrDone(InstrDone), .PCnext(PCnext),
        .ExcReq(ExcReq), .ExcCode(ExcCode), .PCcur(PCcur), .MretReq(MretReq),
        .Irq(Irq), .CsrWe(CsrWe), .CsrAddr(CsrAddr), .CsrWdata(CsrWdata),
        .CsrRdata(CsrRdata), .PCLoad(PCLoad), .TrapPC(TrapPC), .TrapTaken(TrapTaken),
        .Stall(Stall), .InTrap(InTrap), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    // Architectural model: a trap is applied atomically when accepted; the schedule
    // variables record when the pipeline-visible outputs must appear.
    int          cyc = 0, freeAt = 0, loadP = -10, stLo = -10, stHi = -11, mDepth = 0;
    bit          loadTrap = 0, mHalt = 0, mIe = 0;
    bit          mPie [2];
    logic [3:0]  mIen = 0;
    logic [63:0] mEpc [2];
    logic [63:0] mCause [2];
    logic [63:0] mTarget = 0;

    function automatic logic [63:0] expCsr(input logic [1:0] a);
        int t;
        t = (mDepth > 0) ? mDepth - 1 : 0;
        case (a)
            2'd0:    return {62'd0, mPie[t], mIe};
            2'd1:    return {60'd0, mIen};
            2'd2:    return mEpc[t];
            default: return mCause[t];
        endcase
    endfunction

    task automatic enter(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] target);
        mEpc[mDepth]   = pc;
        mCause[mDepth] = cause;
        mPie[mDepth]   = mIe;
        mIe      = 0;
        mDepth++;
        mTarget  = target;
        loadTrap = 1;
        stLo = cyc; stHi = cyc + 1; loadP = cyc + 1; freeAt = cyc + 2;
    endtask

    initial begin : model
        int t, idx;
        logic [3:0] act;
        forever begin
            @(posedge Clk);
            cyc++;
            t = (mDepth > 0) ? mDepth - 1 : 0;
            if (!Reset) begin
                mHalt = 0; mIe = 0; mIen = 0; mDepth = 0;
                for (int i = 0; i < 2; i++) begin mEpc[i] = 0; mCause[i] = 0; mPie[i] = 0; end
                freeAt = cyc; loadP = -10; stLo = -10; stHi = -11;
            end else if (!mHalt && cyc - 1 >= freeAt) begin
                act = Irq & mIen;
                if (ExcReq) begin
                    if (mDepth == MAXD) mHalt = 1;
                    else enter(PCcur, {60'd0, ExcCode}, BASE + 64'(ExcCode) * 4);
                end else if (MretReq && mDepth > 0) begin
                    mTarget = mEpc[t]; mIe = mPie[t]; mDepth--;
                    loadTrap = 0; stLo = cyc; stHi = cyc; loadP = cyc; freeAt = cyc + 1;
                end else if (InstrDone && mIe && act != 0 && mDepth < MAXD) begin
                    idx = 0;
                    for (int i = 0; i < NUM_IRQ; i++) if (act[i]) begin idx = i; break; end
                    enter(PCnext, 64'h8000_0000_0000_0000 | 64'(idx), BASE + 4 * (16 + 64'(idx)));
                end else if (CsrWe) begin
                    case (CsrAddr)
                        2'd0: begin mIe = CsrWdata[0]; mPie[t] = CsrWdata[1]; end
                        2'd1: mIen = CsrWdata[3:0];
                        2'd2: mEpc[t] = CsrWdata & ~64'h3;
                        default: mCause[t] = CsrWdata;
                    endcase
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge Clk);
            if (cyc >= 1) begin
                chk("Stall", 64'(Stall), 64'(mHalt || (cyc >= stLo && cyc <= stHi)));
                chk("PCLoad", 64'(PCLoad), 64'(cyc == loadP));
                chk("TrapTaken", 64'(TrapTaken), 64'(cyc == loadP && loadTrap));
                chk("Halted", 64'(Halted), 64'(mHalt));
                if (cyc == loadP) chk("TrapPC", TrapPC, mTarget);
                if (cyc >= freeAt) begin
                    chk("InTrap", 64'(InTrap), 64'(mDepth > 0));
                    chk("CsrRdata", CsrRdata, expCsr(CsrAddr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fire();
        tick();
        ExcReq = 0; MretReq = 0; InstrDone = 0; CsrWe = 0;
    endtask

    task automatic csrWrite(input logic [1:0] a, input logic [63:0] d);
        CsrWe = 1; CsrAddr = a; CsrWdata = d;
        tick();
        CsrWe = 0;
    endtask

    task automatic csrRead(input string n, input logic [1:0] a, input logic [63:0] e);
        CsrAddr = a;
        #1;
        chk(n, CsrRdata, e);
    endtask

    task automatic chkLoad(input string n, input logic [63:0] pc, input bit taken);
        chk({n, " PCLoad"}, 64'(PCLoad), 64'd1);
        chk({n, " TrapPC"}, TrapPC, pc);
        chk({n, " TrapTaken"}, 64'(TrapTaken), 64'(taken));
    endtask

    initial begin
        // Reset with every stimulus active.
        ExcReq = 1; MretReq = 1; InstrDone = 1; Irq = '1; CsrWe = 1;
        CsrAddr = CSR_IEN; CsrWdata = '1; PCcur = 64'h40; PCnext = 64'h44;
        tick(); tick();
        CsrAddr = CSR_CAUSE; #1;
        chk("rst PCLoad", 64'(PCLoad), 0); chk("rst TrapPC", TrapPC, 0);
        chk("rst TrapTaken", 64'(TrapTaken), 0); chk("rst Stall", 64'(Stall), 0);
        chk("rst InTrap", 64'(InTrap), 0); chk("rst Halted", 64'(Halted), 0);
        chk("rst CAUSE", CsrRdata, 0);
        Reset = 1; ExcReq = 0; MretReq = 0; InstrDone = 0; Irq = 0; CsrWe = 0; CsrWdata = 0;
        tick();

        // Synchronous exception.
        ExcReq = 1; ExcCode = 4'd2; PCcur = 64'h40;
        fire();
        chk("exc save Stall", 64'(Stall), 1);
        tick(); chkLoad("exc", 64'h108, 1);
        tick();
        csrRead("exc EPC", CSR_EPC, 64'h40);
        csrRead("exc CAUSE", CSR_CAUSE, 64'h2);
        chk("exc InTrap", 64'(InTrap), 1);

        MretReq = 1; fire(); chkLoad("mret1", 64'h40, 0);
        tick(); chk("mret1 InTrap", 64'(InTrap), 0);

        // Interrupt: lowest enabled active line is 1.
        csrWrite(CSR_IEN, 64'hFFFF_FFFF_FFFF_FFFA);
        csrRead("IEN trunc", CSR_IEN, 64'hA);
        csrWrite(CSR_STATUS, 64'h1);
        Irq = 4'b1110; InstrDone = 1; PCnext = 64'h80;
        fire(); Irq = 0;
        tick(); chkLoad("irq", 64'h144, 1);
        tick();
        csrRead("irq CAUSE", CSR_CAUSE, 64'h8000_0000_0000_0001);
        csrRead("irq EPC", CSR_EPC, 64'h80);
        csrRead("irq STATUS", CSR_STATUS, 64'h2);

        MretReq = 1; fire(); chkLoad("mret2", 64'h80, 0);
        tick();
        csrRead("mret2 STATUS", CSR_STATUS, 64'h3);
        chk("mret2 InTrap", 64'(InTrap), 0);

        // Stray mret and an interrupt without InstrDone are both ignored.
        MretReq = 1; fire(); chk("stray mret PCLoad", 64'(PCLoad), 0);
        Irq = 4'b0010; fire(); chk("no InstrDone Stall", 64'(Stall), 0);
        Irq = 0;
        csrWrite(CSR_EPC, 64'h1237);
        csrRead("EPC align", CSR_EPC, 64'h1234);

        // CSR write colliding with trap acceptance is dropped.
        ExcReq = 1; ExcCode = 4'd5; PCcur = 64'h200;
        CsrWe = 1; CsrAddr = CSR_IEN; CsrWdata = 0;
        fire();
        tick(); chkLoad("exc+csr", 64'h114, 1);
        tick();
        csrRead("exc+csr IEN", CSR_IEN, 64'hA);
        csrRead("exc+csr EPC", CSR_EPC, 64'h200);

        // Exception and mret together inside a handler.
        ExcReq = 1; MretReq = 1; ExcCode = 4'd3; PCcur = 64'h300;
        fire();
`ifdef TRAP_NEST_EN
        tick(); chkLoad("nest", 64'h10C, 1);
        tick(); csrRead("nest EPC", CSR_EPC, 64'h300);
        MretReq = 1; fire(); chkLoad("nest pop1", 64'h300, 0);
        tick(); chk("nest pop1 InTrap", 64'(InTrap), 1);
        MretReq = 1; fire(); chkLoad("nest pop2", 64'h200, 0);
        tick(); chk("nest pop2 InTrap", 64'(InTrap), 0);
`else
        chk("halt Halted", 64'(Halted), 1);
        chk("halt PCLoad", 64'(PCLoad), 0);
        for (int i = 0; i < 4; i++) begin MretReq = 1; ExcReq = (i == 2); fire(); end
        chk("halt sticky", 64'(Halted), 1);
        csrRead("halt EPC", CSR_EPC, 64'h200);
        Reset = 0; tick(); Reset = 1;
        chk("halt reset Halted", 64'(Halted), 0);
        chk("halt reset Stall", 64'(Stall), 0);
        tick();
`endif

        // Exception outranks a simultaneous interrupt; highest exception code.
        csrWrite(CSR_IEN, 64'hF);
        csrWrite(CSR_STATUS, 64'h1);
        Irq = 4'hF; InstrDone = 1; ExcReq = 1; ExcCode = 4'hF; PCcur = 64'h10;
        fire(); Irq = 0;
        tick(); chkLoad("exc15", 64'h13C, 1);
        tick(); csrRead("exc15 CAUSE", CSR_CAUSE, 64'hF);
        MretReq = 1; fire(); tick();

        // Interrupt with all lines active picks index 0.
        Irq = 4'hF; InstrDone = 1; PCnext = 64'h500;
        fire(); Irq = 0;
        tick(); chkLoad("irq0", 64'h140, 1);
        tick(); csrRead("irq0 CAUSE", CSR_CAUSE, 64'h8000_0000_0000_0000);
        MretReq = 1; fire(); chkLoad("mret3", 64'h500, 0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
Name: trap_unit

Overview:
- Parametrised exception/interrupt controller that supersedes the fixed EPC/cause registers and the hard-wired exception-address mux of the multicycle RISC-V datapath.
- Sits beside the control unit and takes exception and interrupt requests at instruction boundaries.
- Saves EPC and cause, then forces a vectored PC load.
- Restores state on a trap-return (mret) and exposes its registers through a small CSR port.

Parameters:
XLEN, 64, datapath/PC width
NUM_IRQ, 4, number of level-sensitive interrupt lines (1..16)
CAUSE_W, 4, width of the synchronous exception code
TRAP_BASE, 64'h0000_0000_0000_0100, handler vector table base (truncated to XLEN)

Ports:
Clk  input  1  clock
Reset  input  1  reset; one clock, synchronous, active-low
InstrDone  input  1  pulse: current instruction retiring; interrupts are sampled only here
PCnext  input  XLEN  PC of the next instruction; valid with InstrDone
ExcReq  input  1  synchronous exception pulse from the control unit
ExcCode  input  CAUSE_W  exception code; valid with ExcReq
PCcur  input  XLEN  address of the faulting instruction; valid with ExcReq
MretReq  input  1  trap-return pulse
Irq  input  NUM_IRQ  interrupt lines, level
CsrWe  input  1  CSR write strobe
CsrAddr  input  2  0=STATUS 1=IEN 2=EPC 3=CAUSE
CsrWdata  input  XLEN  CSR write data
CsrRdata  output  XLEN  CSR read data, combinational on CsrAddr
PCLoad  output  1  force PC <= TrapPC
TrapPC  output  XLEN  redirect target
TrapTaken  output  1  one-cycle pulse on trap entry
Stall  output  1  control unit must hold in current state
InTrap  output  1  handler active
Halted  output  1  unrecoverable double fault

Behaviour:
- Reset (Reset==0 at a rising edge) values:
  - FSM=IDLE.
  - EPC=0, CAUSE=0.
  - STATUS.IE=0, STATUS.PIE=0, IEN=0.
  - All outputs are 0, except CsrRdata, which reflects the reset CSR values.
  - Reset overrides any state, including HALT.
- FSM states: IDLE, SAVE, REDIRECT, RETURN, HALT.
- IDLE, priority order:
  - ExcReq is highest.
  - Next is MretReq.
  - Lowest is an interrupt. An interrupt is taken only when InstrDone=1, STATUS.IE=1, and (Irq & IEN) != 0.
  - Among interrupts, the lowest index wins.
- Latched request:
  - The winning request latches into internal pending registers.
  - FSM goes to SAVE (or RETURN for mret).
- SAVE, 1 cycle:
  - Stall=1.
  - EPC <= PCcur for an exception, or PCnext for an interrupt.
  - CAUSE <= {0, ExcCode} for an exception.
  - CAUSE <= {1'b1, 0, idx} for an interrupt, with the MSB at bit XLEN-1.
  - PIE <= IE, then IE <= 0.
  - Go to REDIRECT.
- REDIRECT, 1 cycle:
  - PCLoad=1, TrapTaken=1, Stall=1.
  - TrapPC = TRAP_BASE + 4*ExcCode for an exception, or TRAP_BASE + 4*(2**CAUSE_W + idx) for an interrupt.
  - InTrap <= 1.
  - Go to IDLE.
- Latency: request at cycle N -> SAVE at N+1 -> PCLoad at N+2.
- RETURN, 1 cycle:
  - PCLoad=1 with TrapPC=EPC, Stall=1.
  - IE <= PIE, InTrap <= 0.
  - Go to IDLE.
- MretReq with InTrap=0: ignored, no state change.
- ExcReq and MretReq in the same cycle: the exception wins and the mret is dropped.
- ExcReq while InTrap=1 (build without nesting): go to HALT.
  - In HALT: Halted=1, Stall=1, PCLoad=0. HALT is left only by reset.
- CSR writes:
  - Accepted only in IDLE.
  - A write in the same cycle as trap acceptance, or in any non-IDLE state, is dropped.
  - IEN writes keep bits [NUM_IRQ-1:0]; STATUS keeps bits [1:0]; other bits read 0.
  - EPC writes force bits [1:0]=0.
- Irq deasserting after acceptance does not cancel the trap; the latched index is used.
- Arithmetic is modulo 2^XLEN; TrapPC wrap-around is allowed and not flagged.

Optional Feature:
TRAP_NEST_EN
- Defined:
  - EPC, CAUSE and PIE become a 2-entry stack.
  - Trap entry while InTrap pushes the stack; mret pops it and keeps InTrap=1 until depth returns to 0.
  - An exception at depth 2 goes to HALT.
  - Interrupts remain masked in the handler (IE=0) unless the handler sets STATUS.IE.
  - The CSR port accesses the top of stack.
- Undefined: single level only, with the double-fault HALT behaviour described above.

Decomposition:
- Package trap_pkg holds:
  - the state enum trap_state_t;
  - the CSR address localparams CSR_STATUS/CSR_IEN/CSR_EPC/CSR_CAUSE;
  - the STATUS bit indices IE_BIT=0, PIE_BIT=1;
  - the function vec_addr(base, slot).
- Sub-module irq_prio_enc(NUM_IRQ): combinational masked lowest-index priority encoder with a valid flag.

Test Plan:
- Reset low for 2 cycles with stimuli active -> all outputs 0, CsrRdata(CAUSE)=0.
- ExcReq, ExcCode=2, PCcur=0x40 -> PCLoad at N+2, TrapPC=0x108, EPC=0x40, CAUSE=2, InTrap=1.
- IEN=0b1010, IE=1, Irq=0b1110, InstrDone, PCnext=0x80 -> idx 1 taken, CAUSE=0x8000_0000_0000_0001, TrapPC=0x144, EPC=0x80, IE=0, PIE=1.
- After the entry above, MretReq -> PCLoad with TrapPC=0x80, IE=1, InTrap=0.
- ExcReq and MretReq together with InTrap=1 -> non-nest build: Halted=1 and stays set until reset; nest build: depth 2, EPC=new PCcur, two mrets needed to return.
- CsrWe to IEN in the same cycle as ExcReq -> IEN unchanged, trap taken normally.
